// File: rtl/aexm_pkg.sv
// Shared encodings for the AEXM hazard unit: instruction kinds and the age at
// which each kind's result becomes forwardable.
package aexm_pkg;

   localparam logic [1:0] KIND_ALU   = 2'd0;
   localparam logic [1:0] KIND_LOAD  = 2'd1;
   localparam logic [1:0] KIND_MULTI = 2'd2;
   localparam logic [1:0] KIND_RSVD  = 2'd3;

   localparam int unsigned RDY_ALU  = 0;
   localparam int unsigned RDY_LOAD = 1;

   // Multi-cycle latency is a unit parameter, so it is passed in rather than fixed here.
   function automatic int unsigned ready_req(input logic [1:0] kind, input int unsigned mlat);
      int unsigned req;
      req = RDY_ALU;
      unique case (kind)
         KIND_ALU, KIND_RSVD: req = RDY_ALU;
         KIND_LOAD:           req = RDY_LOAD;
         KIND_MULTI:          req = mlat;
      endcase
      return req;
   endfunction

endpackage

// File: rtl/aexm_hz_stage.sv
// One in-flight result record {valid, rd, kind, age} of the hazard unit pipeline.
// The first stage loads age 0; later stages take the upstream age plus one, saturating.
module aexm_hz_stage
   import aexm_pkg::*;
#(
   parameter int unsigned AW      = 5,
   parameter int unsigned AGEW    = 2,
   parameter int unsigned AGE_MAX = 3,
   parameter bit          FIRST   = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            kill,
   input  logic            in_valid,
   input  logic [AW-1:0]   in_rd,
   input  logic [1:0]      in_kind,
   input  logic [AGEW-1:0] in_age,
   output logic            valid,
   output logic [AW-1:0]   rd,
   output logic [1:0]      kind,
   output logic [AGEW-1:0] age
);

   logic            valid_nxt;
   logic [AGEW-1:0] age_nxt;

   always_comb begin
      valid_nxt = in_valid & ~kill;
      if (FIRST) begin
         age_nxt = '0;
      end else if (32'(in_age) >= AGE_MAX) begin
         age_nxt = AGEW'(AGE_MAX);
      end else begin
         age_nxt = in_age + AGEW'(1);
      end
   end

   // Dead records carry rd=0 so the retire port never shows a stale address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         rd    <= '0;
         kind  <= KIND_ALU;
         age   <= '0;
      end else if (en) begin
         valid <= valid_nxt;
         rd    <= valid_nxt ? in_rd : '0;
         kind  <= valid_nxt ? in_kind : KIND_ALU;
         age   <= age_nxt;
      end
   end

endmodule

// File: rtl/aexm_hazard_unit.sv
// Operand forwarding select and load/multi-cycle stall detection for the AEXM
// decode stage, tracking DEPTH in-flight destination registers.
module aexm_hazard_unit
   import aexm_pkg::*;
#(
   parameter int unsigned AW    = 5,
   parameter int unsigned DEPTH = 3,
   parameter int unsigned MLAT  = 2,
   localparam int unsigned SW   = $clog2(DEPTH + 1)
) (
   input  logic          gclk,
   input  logic          grst_n,
   input  logic          d_en,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_ra,
   input  logic [AW-1:0] iss_rb,
   input  logic [AW-1:0] iss_rd,
   input  logic          iss_we,
   input  logic [1:0]    iss_kind,
   input  logic          flush,
   output logic [SW-1:0] fwd_sel_a,
   output logic [SW-1:0] fwd_sel_b,
   output logic          stall,
   output logic          wb_we,
   output logic [AW-1:0] wb_rd
);

   logic          st_valid [1:DEPTH];
   logic [AW-1:0] st_rd    [1:DEPTH];
   logic [1:0]    st_kind  [1:DEPTH];
   logic [SW-1:0] st_age   [1:DEPTH];
   logic          st_ready [1:DEPTH];

   logic          in_valid [1:DEPTH];
   logic [AW-1:0] in_rd    [1:DEPTH];
   logic [1:0]    in_kind  [1:DEPTH];
   logic [SW-1:0] in_age   [1:DEPTH];

   logic hit_a, hit_b, rdy_a, rdy_b;

   // A stalled or flushed issue enters stage 1 as a bubble.
   always_comb begin
      in_valid[1] = iss_valid & iss_we & (iss_rd != '0) & ~flush & ~stall;
      in_rd[1]    = iss_rd;
      in_kind[1]  = iss_kind;
      in_age[1]   = '0;
      for (int k = 2; k <= int'(DEPTH); k++) begin
         in_valid[k] = st_valid[k-1];
         in_rd[k]    = st_rd[k-1];
         in_kind[k]  = st_kind[k-1];
         in_age[k]   = st_age[k-1];
      end
   end

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      aexm_hz_stage #(
         .AW     (AW),
         .AGEW   (SW),
         .AGE_MAX(DEPTH),
         .FIRST  (k == 1)
      ) u_stage (
         .clk     (gclk),
         .rst_n   (grst_n),
         .en      (d_en),
         .kill    ((k == 2) ? flush : 1'b0),
         .in_valid(in_valid[k]),
         .in_rd   (in_rd[k]),
         .in_kind (in_kind[k]),
         .in_age  (in_age[k]),
         .valid   (st_valid[k]),
         .rd      (st_rd[k]),
         .kind    (st_kind[k]),
         .age     (st_age[k])
      );
   end

   always_comb begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
         st_ready[k] = 32'(st_age[k]) >= ready_req(st_kind[k], MLAT);
      end
   end

   // Scan oldest to youngest so the youngest match overrides, readiness included.
   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      hit_a     = 1'b0;
      hit_b     = 1'b0;
      rdy_a     = 1'b0;
      rdy_b     = 1'b0;
      for (int k = int'(DEPTH); k >= 1; k--) begin
         if (st_valid[k] && (iss_ra != '0) && (st_rd[k] == iss_ra)) begin
            fwd_sel_a = SW'(k);
            hit_a     = 1'b1;
            rdy_a     = st_ready[k];
         end
         if (st_valid[k] && (iss_rb != '0) && (st_rd[k] == iss_rb)) begin
            fwd_sel_b = SW'(k);
            hit_b     = 1'b1;
            rdy_b     = st_ready[k];
         end
      end
      stall = iss_valid & ((hit_a & ~rdy_a) | (hit_b & ~rdy_b));
   end

   assign wb_we = st_valid[DEPTH];
   assign wb_rd = st_rd[DEPTH];

endmodule

// File: tb/tb_aexm_hazard_unit.sv
// Self-checking bench for aexm_hazard_unit: per-scenario stimulus tables with
// expected outputs queued at drive time and compared at the following negedge.
module tb_aexm_hazard_unit;
   import aexm_pkg::*;

   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned MLAT  = 2;
   localparam int unsigned SW    = 2;

   logic          gclk, grst_n, d_en, iss_valid, iss_we, flush;
   logic [AW-1:0] iss_ra, iss_rb, iss_rd;
   logic [1:0]    iss_kind;
   logic [SW-1:0] fwd_sel_a, fwd_sel_b;
   logic          stall, wb_we;
   logic [AW-1:0] wb_rd;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] ra, rb, rd;
      logic          we;
      logic [1:0]    kind;
      logic          fl;
      logic          den;
   } stim_t;

   typedef struct packed {
      logic          stall;
      logic [SW-1:0] sa, sb;
      logic          we;
      logic [AW-1:0] rd;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   aexm_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .MLAT(MLAT)) dut (
      .gclk     (gclk),
      .grst_n   (grst_n),
      .d_en     (d_en),
      .iss_valid(iss_valid),
      .iss_ra   (iss_ra),
      .iss_rb   (iss_rb),
      .iss_rd   (iss_rd),
      .iss_we   (iss_we),
      .iss_kind (iss_kind),
      .flush    (flush),
      .fwd_sel_a(fwd_sel_a),
      .fwd_sel_b(fwd_sel_b),
      .stall    (stall),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic stim_t st(int v, int ra, int rb, int rd, int we, int kind, int fl, int den);
      stim_t s;
      s.v = (v != 0);  s.ra = AW'(ra);  s.rb = AW'(rb);  s.rd = AW'(rd);
      s.we = (we != 0); s.kind = 2'(kind); s.fl = (fl != 0); s.den = (den != 0);
      return s;
   endfunction

   function automatic exp_t ex(int stl, int sa, int sb, int we, int rd);
      exp_t e;
      e.stall = (stl != 0); e.sa = SW'(sa); e.sb = SW'(sb); e.we = (we != 0); e.rd = AW'(rd);
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.stall = stall; o.sa = fwd_sel_a; o.sb = fwd_sel_b; o.we = wb_we; o.rd = wb_rd;
      return o;
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("stall=%0b sel_a=%0d sel_b=%0d wb_we=%0b wb_rd=%0d",
                       e.stall, e.sa, e.sb, e.we, e.rd);
   endfunction

   task automatic apply(input stim_t s);
      iss_valid = s.v;  iss_ra = s.ra;     iss_rb = s.rb; iss_rd = s.rd;
      iss_we    = s.we; iss_kind = s.kind; flush = s.fl;  d_en = s.den;
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 3, 4, 3, 1, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 3, 4, 4, 1, KIND_LOAD, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 3, 4, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         if (i == 2) grst_n = 1'b1;
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_alu_fwd();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 0, 0, 3, 1, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 3, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 1, 0, 0, 0));
      s.push_back(st(1, 0, 3, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 2, 0, 0));
      s.push_back(st(1, 3, 3, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 3, 3, 1, 3));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL alu_fwd[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_load_stall();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 0, 0, 4, 1, KIND_LOAD, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 0, 4, 9, 1, KIND_ALU, 0, 1));  e.push_back(ex(1, 0, 1, 0, 0));
      s.push_back(st(1, 0, 4, 9, 1, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 2, 0, 0));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 0, 1, 4));
      s.push_back(st(0, 9, 0, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(0, 2, 0, 0, 0));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 0, 1, 9));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL load_stall[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_multi_stall();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 0, 0, 5, 1, KIND_MULTI, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 5, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(1, 1, 0, 0, 0));
      s.push_back(st(1, 5, 0, 0, 0, KIND_ALU, 0, 0));   e.push_back(ex(1, 2, 0, 0, 0));
      s.push_back(st(1, 5, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(1, 2, 0, 0, 0));
      s.push_back(st(1, 5, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 3, 0, 1, 5));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL multi_stall[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_flush();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 0, 0, 6, 1, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 0, 0, 8, 1, KIND_ALU, 1, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 6, 8, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      // Flush while the pipeline is frozen must leave stage 1 intact.
      s.push_back(st(1, 0, 0, 6, 1, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 6, 0, 0, 0, KIND_ALU, 1, 0)); e.push_back(ex(0, 1, 0, 0, 0));
      s.push_back(st(1, 6, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 1, 0, 0, 0));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 1, 6));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL flush[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 0, 0, 7, 1, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 0, 0, 7, 1, KIND_RSVD, 0, 1));  e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 7, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 1, 0, 0, 0));
      s.push_back(st(1, 0, 7, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 2, 1, 7));
      s.push_back(st(1, 0, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 1, 7));
      // Younger unready LOAD must not be masked by an older ready ALU to the same register.
      s.push_back(st(1, 0, 0, 10, 1, KIND_ALU, 0, 1));  e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 0, 0, 10, 1, KIND_LOAD, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 10, 0, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(1, 1, 0, 0, 0));
      s.push_back(st(1, 10, 0, 0, 0, KIND_ALU, 0, 1));  e.push_back(ex(0, 2, 0, 1, 10));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 1, 10));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   task automatic test_reset_midstream();
      stim_t s[$];
      exp_t  e[$];
      exp_t  got, want;
      s.push_back(st(1, 0, 0, 11, 1, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 0, 0, 12, 1, KIND_MULTI, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(1, 0, 0, 13, 1, KIND_LOAD, 0, 1));  e.push_back(ex(0, 0, 0, 0, 0));
      for (int j = 0; j < 5; j++) begin
         s.push_back(st(1, 13, 12, 0, 0, KIND_ALU, 0, 0)); e.push_back(ex(1, 1, 2, 1, 11));
      end
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL full_freeze[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end

      #2 grst_n = 1'b0;
      sb_q.push_back(ex(0, 0, 0, 0, 0));
      #1;
      got = observe(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL rst_async: got %s, want %s", fmt(got), fmt(want));
      end
      sb_q.push_back(ex(0, 0, 0, 0, 0));
      @(negedge gclk);
      got = observe(); want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL rst_hold: got %s, want %s", fmt(got), fmt(want));
      end
      @(posedge gclk); #1;
      grst_n = 1'b1;

      s.delete();
      e.delete();
      for (int j = 0; j < 5; j++) begin
         s.push_back(st(1, 13, 12, 14, 1, KIND_ALU, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0));
      end
      s.push_back(st(1, 14, 13, 0, 0, KIND_ALU, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0));
      s.push_back(st(0, 0, 0, 0, 0, KIND_ALU, 0, 1));   e.push_back(ex(0, 0, 0, 0, 0));
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i]);
         sb_q.push_back(e[i]);
         @(negedge gclk);
         got = observe(); want = sb_q.pop_front(); n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL post_reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
         end
         @(posedge gclk); #1;
      end
   endtask

   initial begin
      grst_n = 1'b0;
      apply(st(0, 0, 0, 0, 0, KIND_ALU, 0, 0));
      @(posedge gclk); #1;
      test_reset();
      test_alu_fwd();
      test_load_stall();
      test_multi_stall();
      test_flush();
      test_back_to_back();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
